// File: rtl/uart_tx_if.sv
// Word handshake into the debug UART transmitter.
// The master offers dat/val; the transmitter answers with rdy.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] dat;
  logic                 val;
  logic                 rdy;

  modport master (
    output dat,
    output val,
    input  rdy
  );

  modport slave (
    input  dat,
    input  val,
    output rdy
  );
endinterface

// File: rtl/uart_tx.sv
// Debug console UART transmitter.
// Serialises one word per handshake onto an idle-high line, LSB first.
module uart_tx #(
  parameter int       DATA_BITS   = 8,
  parameter int       STOP_BITS   = 1,
  parameter bit [1:0] PARITY_MODE = 2'd0,
  parameter int       BAUD_RATE   = 115200,
  parameter int       CLK_FREQ    = 50000000
) (
  input  logic clk,
  input  logic rst,
  uart_tx_if.slave s,
  output logic tx,
  output logic busy
);

  localparam int BAUD_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int TW = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam bit PAR_EN = (PARITY_MODE == 2'd1) ||
                          (PARITY_MODE == 2'd2);

  if (BAUD_TICKS < 2) begin : g_baud_chk
    $error("uart_tx: BAUD_TICKS must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_data_chk
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        tick, tick_nxt;
  logic [BW-1:0]        bitn, bitn_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par, par_nxt;
  logic                 rdy_q;
  logic                 tx_nxt, rdy_nxt, busy_nxt;
  logic                 accept;
  logic                 bit_end;

  assign accept  = s.val & rdy_q;
  assign bit_end = (tick == TW'(BAUD_TICKS - 1));
  assign s.rdy   = rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tick  <= '0;
      bitn  <= '0;
      shift <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
      rdy_q <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      tick  <= tick_nxt;
      bitn  <= bitn_nxt;
      shift <= shift_nxt;
      par   <= par_nxt;
      tx    <= tx_nxt;
      rdy_q <= rdy_nxt;
      busy  <= busy_nxt;
    end
  end

  // bitn counts data bits in DATA and stop bits in STOP
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    bitn_nxt  = bitn;
    shift_nxt = shift;
    par_nxt   = par;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
          tick_nxt  = '0;
          bitn_nxt  = '0;
          shift_nxt = s.dat;
          par_nxt   = (PARITY_MODE == 2'd2) ? ~^s.dat : ^s.dat;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          tick_nxt  = '0;
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          tick_nxt  = '0;
          shift_nxt = shift >> 1;
          if (bitn == BW'(DATA_BITS - 1)) begin
            bitn_nxt  = '0;
            state_nxt = PAR_EN ? PARITY : STOP;
          end else begin
            bitn_nxt = bitn + BW'(1);
          end
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          tick_nxt  = '0;
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          tick_nxt = '0;
          if (bitn == BW'(STOP_BITS - 1)) begin
            bitn_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            bitn_nxt = bitn + BW'(1);
          end
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        tick_nxt  = '0;
        bitn_nxt  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register with it
  always_comb begin
    tx_nxt   = 1'b1;
    rdy_nxt  = 1'b0;
    busy_nxt = 1'b1;
    unique case (state_nxt)
      IDLE: begin
        rdy_nxt  = 1'b1;
        busy_nxt = 1'b0;
      end
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      STOP:    tx_nxt = 1'b1;
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter for the debug path. It accepts one data word per valid/ready handshake and serialises it LSB-first onto an idle-high line. The frame is a start bit, DATA_BITS data bits, an optional parity bit and STOP_BITS stop bits. It is the transmit side for the debug console and uses the same frame parameters as the debug receiver.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
STOP_BITS, 1, stop bits per frame (1 or 2)
PARITY_MODE, 0, 2-bit: 0 none, 1 even, 2 odd, 3 reserved (treated as none)
BAUD_RATE, 115200, line bit rate in bit/s
CLK_FREQ, 50000000, clk frequency in Hz

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
dat  input  DATA_BITS  word to send; sampled only on handshake
val  input  1  dat valid
rdy  output  1  ready to accept a word; high only in IDLE
tx  output  1  serial line, idle high
busy  output  1  frame in progress (high in any state other than IDLE)

Behaviour:
- Reset and clocking:
  - Clock clk; reset rst, synchronous, active-high.
  - During/after reset: state IDLE, tx=1, rdy=1, busy=0, bit and tick counters cleared.
- Bit timing:
  - BAUD_TICKS = CLK_FREQ / BAUD_RATE (integer division).
  - Elaboration-time check: BAUD_TICKS >= 2.
  - Every bit, including start, parity and stop, is held for exactly BAUD_TICKS clk cycles.
  - A tick counter 0..BAUD_TICKS-1 wraps on each bit boundary.
- Handshake:
  - Accept when val=1 and rdy=1 at a rising edge.
  - dat is latched into a shift register on that edge.
  - val without rdy is ignored and dat is not sampled.
  - Changes on dat or val during a frame have no effect.
- States:
  - IDLE: tx=1, rdy=1. On accept -> START; tick counter 0.
  - START: tx=0 for BAUD_TICKS cycles -> DATA.
  - DATA: tx = shift_reg[0]; shift right at each bit end.
    - After DATA_BITS bits -> PARITY if PARITY_MODE is 1 or 2, else STOP.
  - PARITY: tx = ^data for even, ~^data for odd.
    - Parity is computed from the word latched at accept.
    - Held BAUD_TICKS cycles -> STOP.
  - STOP: tx=1 for STOP_BITS*BAUD_TICKS cycles -> IDLE.
- Outputs and latency:
  - tx is registered.
  - The start bit appears on tx in the first cycle after the accept edge.
  - rdy and busy are registered and change in the same cycle the state changes.
- Frame length:
  - F = (1 + DATA_BITS + P + STOP_BITS) * BAUD_TICKS cycles, where P is 1 when parity is enabled, else 0.
  - rdy returns to 1 in the cycle after the last stop-bit cycle.
  - With val held high, back-to-back accept occurs there, so the minimum word-to-word period is F+1 cycles. There is 1 extra idle-high cycle between frames.
- Boundary conditions:
  - Data is 1s (e.g. 0xFF): no glitch between the last data bit and the stop bits.
  - Reset mid-frame: tx=1, rdy=1 on the cycle after the reset edge; the partial frame is dropped.
  - Reset asserted together with val: reset wins and no word is accepted.
- No counter overflow: the bit counter needs ceil(log2(DATA_BITS+1)) bits and the tick counter needs ceil(log2(BAUD_TICKS)) bits.

Test Plan:
- Reset, then idle: CLK_FREQ=1000, BAUD_RATE=250 (BAUD_TICKS=4). Hold rst 3 cycles, keep val=0 -> tx=1, rdy=1, busy=0 throughout.
- Basic frame, PARITY_MODE=0, STOP_BITS=1: send 0xA5 -> tx over 40 cycles is 0,1,0,1,0,0,1,0,1,1 (4 cycles each); rdy=0 for 40 cycles, then 1.
- Parity and stop bits, STOP_BITS=2:
  - PARITY_MODE=1, send 0xA5 -> parity bit 0, frame 48 cycles.
  - PARITY_MODE=2 -> parity bit 1.
  - Send 0x07 with even parity -> parity bit 1.
- Back-to-back: val held high with 0x00 then 0xFF -> second start bit begins exactly 41 cycles after the first start bit. dat changed mid-frame does not alter the first frame.
- Reset mid-frame: assert rst during data bit 3 of 0x55 -> tx=1 and rdy=1 on the next cycle. A new word sent afterwards produces a complete, correct frame.
- Loopback at 50 MHz/115200 into the debug UART receiver: 256 sequential words 0x00..0xFF -> all received equal to sent, in order.
